// File: rtl/video_timing_sched.sv
// Raster timing generator with a frame-aligned pattern index scheduler.
// Optional VTS_PAT_HOLD_EN adds i_pat_hold, which freezes pattern stepping at frame boundaries.
module video_timing_sched #(
  parameter int H_RES          = 640,
  parameter int H_FP           = 16,
  parameter int H_SYNC         = 96,
  parameter int H_BP           = 48,
  parameter int V_RES          = 480,
  parameter int V_FP           = 10,
  parameter int V_SYNC         = 2,
  parameter int V_BP           = 33,
  parameter bit HS_POL         = 1'b0,
  parameter bit VS_POL         = 1'b0,
  parameter int N_PAT          = 4,
  parameter int FRAMES_PER_PAT = 60,
  localparam int H_TOTAL       = H_RES + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL       = V_RES + V_FP + V_SYNC + V_BP,
  localparam int XW            = $clog2(H_TOTAL),
  localparam int YW            = $clog2(V_TOTAL),
  localparam int PW            = $clog2(N_PAT) + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
`ifdef VTS_PAT_HOLD_EN
  input  logic          i_pat_hold,
`endif
  output logic          o_blank,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_sof,
  output logic [PW-1:0] o_pat_id
);

  localparam int FW = $clog2(FRAMES_PER_PAT) + 1;

  localparam logic [XW-1:0] H_ACT_END  = XW'(H_RES - 1);
  localparam logic [XW-1:0] H_FP_END   = XW'(H_RES + H_FP - 1);
  localparam logic [XW-1:0] H_SYNC_END = XW'(H_RES + H_FP + H_SYNC - 1);
  localparam logic [XW-1:0] H_LAST     = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT_END  = YW'(V_RES - 1);
  localparam logic [YW-1:0] V_FP_END   = YW'(V_RES + V_FP - 1);
  localparam logic [YW-1:0] V_SYNC_END = YW'(V_RES + V_FP + V_SYNC - 1);
  localparam logic [YW-1:0] V_LAST     = YW'(V_TOTAL - 1);
  localparam logic [FW-1:0] F_LAST     = FW'(FRAMES_PER_PAT - 1);
  localparam logic [PW-1:0] P_LAST     = PW'(N_PAT - 1);

  typedef enum logic [1:0] {ST_ACTIVE, ST_FP, ST_SYNC, ST_BP} phase_e;

  logic [XW-1:0] h_q, h_d, x_q, x_d;
  logic [YW-1:0] v_q, v_d, y_q, y_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [PW-1:0] pat_q, pat_d, pat_id_q, pat_id_d;
  phase_e        hst_q, hst_d, vst_q, vst_d;
  logic          blank_q, blank_d, hsync_q, hsync_d, vsync_q, vsync_d, sof_q, sof_d;
  logic          h_wrap_s, v_wrap_s, hold_s;

  // Phase advances when the counter sits on the last position of the current phase.
  function automatic phase_e next_phase(input phase_e st, input logic act_end,
                                        input logic fp_end, input logic sync_end,
                                        input logic last);
    phase_e nxt;
    nxt = st;
    case (st)
      ST_ACTIVE: if (act_end)  nxt = ST_FP;
      ST_FP:     if (fp_end)   nxt = ST_SYNC;
      ST_SYNC:   if (sync_end) nxt = ST_BP;
      ST_BP:     if (last)     nxt = ST_ACTIVE;
      default:                 nxt = ST_ACTIVE;
    endcase
    return nxt;
  endfunction

`ifdef VTS_PAT_HOLD_EN
  assign hold_s = i_pat_hold;
`else
  assign hold_s = 1'b0;
`endif

  assign h_wrap_s = (h_q == H_LAST);
  assign v_wrap_s = (v_q == V_LAST);

  always_comb begin
    h_d      = h_q;
    v_d      = v_q;
    hst_d    = hst_q;
    vst_d    = vst_q;
    frame_d  = frame_q;
    pat_d    = pat_q;
    blank_d  = blank_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    x_d      = x_q;
    y_d      = y_q;
    sof_d    = sof_q;
    pat_id_d = pat_id_q;
    if (i_en) begin
      h_d   = h_wrap_s ? '0 : h_q + 1'b1;
      hst_d = next_phase(hst_q, h_q == H_ACT_END, h_q == H_FP_END, h_q == H_SYNC_END, h_wrap_s);
      if (h_wrap_s) begin
        v_d   = v_wrap_s ? '0 : v_q + 1'b1;
        vst_d = next_phase(vst_q, v_q == V_ACT_END, v_q == V_FP_END, v_q == V_SYNC_END, v_wrap_s);
      end
      // Pattern only steps at the frame's last pixel, so the new index lands with the next sof.
      if (h_wrap_s && v_wrap_s && !hold_s) begin
        if (frame_q == F_LAST) begin
          frame_d = '0;
          pat_d   = (pat_q == P_LAST) ? '0 : pat_q + 1'b1;
        end else begin
          frame_d = frame_q + 1'b1;
        end
      end
      blank_d  = !(hst_q == ST_ACTIVE && vst_q == ST_ACTIVE);
      hsync_d  = (hst_q == ST_SYNC) ? HS_POL : ~HS_POL;
      vsync_d  = (vst_q == ST_SYNC) ? VS_POL : ~VS_POL;
      x_d      = h_q;
      y_d      = v_q;
      sof_d    = (h_q == '0) && (v_q == '0);
      pat_id_d = pat_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_q      <= '0;
      v_q      <= '0;
      hst_q    <= ST_ACTIVE;
      vst_q    <= ST_ACTIVE;
      frame_q  <= '0;
      pat_q    <= '0;
      blank_q  <= 1'b1;
      hsync_q  <= ~HS_POL;
      vsync_q  <= ~VS_POL;
      x_q      <= '0;
      y_q      <= '0;
      sof_q    <= 1'b0;
      pat_id_q <= '0;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      hst_q    <= hst_d;
      vst_q    <= vst_d;
      frame_q  <= frame_d;
      pat_q    <= pat_d;
      blank_q  <= blank_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      x_q      <= x_d;
      y_q      <= y_d;
      sof_q    <= sof_d;
      pat_id_q <= pat_id_d;
    end
  end

  assign o_blank  = blank_q;
  assign o_hsync  = hsync_q;
  assign o_vsync  = vsync_q;
  assign o_x      = x_q;
  assign o_y      = y_q;
  assign o_sof    = sof_q;
  assign o_pat_id = pat_id_q;

endmodule
